// File: rtl/mch_pkg.sv
// Shared types and helpers for the Manchester sync sequencer and the bit encoder.
// Holds the count-width helper, the state decode and the nominal pacing tick rate.
package mch_pkg;

    localparam int TICK_HZ = 1_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Bits needed to hold 0..max_val, i.e. clog2(max_val+1).
    function automatic int cnt_w(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) <= max_val) w = i + 1;
        return w;
    endfunction

    function automatic seq_state_e seq_state(input int cnt, input int sync_len, input int term);
        if (cnt >= term)         return ST_IDLE;
        else if (cnt < sync_len) return ST_SYNC;
        else                     return ST_DONE;
    endfunction

endpackage

// File: rtl/mch_edge_det.sv
// Two-flop edge detector on a clk-synchronous pulse; rise/fall are one clk wide.
module mch_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic d0_q, d1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_q <= 1'b0;
            d1_q <= 1'b0;
        end else begin
            d0_q <= d_i;
            d1_q <= d0_q;
        end
    end

    assign rise_o = d0_q & ~d1_q;
    assign fall_o = d1_q & ~d0_q;

endmodule

// File: rtl/mch_sync_seq.sv
// Manchester sync/preamble sequencer: tick-paced sync waveform followed by a done window.
// Define MCH_SYNC_POL_EN to add a `pol` input that inverts the sync cells per sequence.
//   state | meaning
//   IDLE  | cnt == TERM, waiting for a start edge
//   SYNC  | cnt <  SYNC_LEN, driving sync cells
//   DONE  | SYNC_LEN <= cnt < TERM, done window
module mch_sync_seq
    import mch_pkg::*;
#(
    parameter int SYNC_LEN  = 11,
    parameter int HALF_LOG2 = 1,
    parameter int DONE_LEN  = 4,
    parameter bit IDLE_LVL  = 1'b1,
    parameter bit RETRIG    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pls_tick,
    input  logic start,
`ifdef MCH_SYNC_POL_EN
    input  logic pol,
`endif
    output logic async,
    output logic done,
    output logic busy,
    output logic err_retrig
);
    localparam int TERM  = SYNC_LEN + DONE_LEN;
    localparam int CNT_W = cnt_w(TERM);
    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);

    logic             tick_r, tick_f;
    logic             st0_q, st1_q, start_edge;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             async_q, async_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clr, pol_eff;
    seq_state_e       state;

    mch_edge_det u_tick_det (
        .clk    (clk),
        .rst    (rst),
        .d_i    (pls_tick),
        .rise_o (tick_r),
        .fall_o (tick_f)
    );

    assign start_edge = st0_q & ~st1_q;
    assign state      = seq_state(int'(cnt_q), SYNC_LEN, TERM);
    assign busy       = (state != ST_IDLE);
    assign clr        = tick_f & start_edge & (~busy | RETRIG);

`ifdef MCH_SYNC_POL_EN
    logic pol_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      pol_q <= 1'b0;
        else if (clr) pol_q <= pol;
    end
    assign pol_eff = pol_q;
`else
    assign pol_eff = 1'b0;
`endif

    // Count moves on tick fall, outputs on tick rise, so a clear never races an output update.
    always_comb begin
        cnt_d   = cnt_q;
        async_d = async_q;
        done_d  = done_q;
        err_d   = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (tick_f) begin
            if (busy) cnt_d = cnt_q + CNT_W'(1);
            err_d = start_edge & busy & ~RETRIG;
        end
        if (tick_r) begin
            async_d = (state == ST_SYNC) ? (cnt_q[HALF_LOG2] ^ pol_eff) : IDLE_LVL;
            done_d  = (state == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st0_q   <= 1'b0;
            st1_q   <= 1'b0;
            cnt_q   <= TERM_C;
            async_q <= IDLE_LVL;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (tick_r) begin
                st0_q <= start;
                st1_q <= st0_q;
            end
            cnt_q   <= cnt_d;
            async_q <= async_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign async      = async_q;
    assign done       = done_q;
    assign err_retrig = err_q;

endmodule
